ili9341_spi_reader: RTL and testbench

//  SPI read-transaction engine for the ILI9341 (mode 0, MSB first): sends one command byte (DC=0),

---
 rtl/ili9341_spi_reader_pkg.sv | 21 ++
 rtl/ili9341_spi_reader_sck_gen.sv | 39 +++
 rtl/ili9341_spi_reader.sv | 164 ++++++++++++++++
 tb/tb_ili9341_spi_reader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ili9341_spi_reader_pkg.sv
// Shared types and constants for the ILI9341 SPI read-transaction engine.
// Holds the FSM state type, well-known read opcodes and the response-length clamp.
package ili9341_spi_reader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      DUMMY,
      READ,
      END
   } rd_state_t;

   localparam logic [7:0] CMD_RDDID = 8'h04;
   localparam logic [7:0] CMD_RDDST = 8'h09;
   localparam logic [7:0] CMD_RDID4 = 8'hD3;

   function automatic int clamp_nbytes(input int n, input int max_bytes);
      return (n > max_bytes) ? max_bytes : n;
   endfunction

endpackage

// File: rtl/ili9341_spi_reader_sck_gen.sv
// SCK divider: toggles SCK every CLK_DIV clk while enabled and flags the clk edge
// on which SCK will rise or fall, so the FSM can act on exactly that edge.
module ili9341_spi_reader_sck_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic sck,
   output logic rise,
   output logic fall
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] div_cnt;
   logic          tick;

   // Strobes are combinational so the FSM samples/shifts on the same edge SCK moves.
   assign tick = en && (div_cnt == CW'(CLK_DIV - 1));
   assign rise = tick && !sck;
   assign fall = tick && sck;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= '0;
         sck     <= 1'b0;
      end else if (!en) begin
         div_cnt <= '0;
         sck     <= 1'b0;
      end else if (tick) begin
         div_cnt <= '0;
         sck     <= ~sck;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/ili9341_spi_reader.sv
// ILI9341 SPI read engine (mode 0, MSB first): command byte with DC=0, dummy clocks,
// then 0..MAX_BYTES response bytes shifted in from MISO with DC=1.
module ili9341_spi_reader
   import ili9341_spi_reader_pkg::*;
#(
   parameter int DW         = 8,
   parameter int CLK_DIV    = 4,
   parameter int DUMMY_BITS = 1,
   parameter int MAX_BYTES  = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_start,
   input  logic [DW-1:0] i_cmd,
   input  logic [2:0]    i_nbytes,
   input  logic          i_miso,
   output logic          o_sck,
   output logic          o_mosi,
   output logic          o_cs,
   output logic          o_dc,
   output logic          o_busy,
   output logic [DW-1:0] o_rd_data,
   output logic          o_rd_valid,
   output logic          o_done
);

   localparam int CNT_W = $clog2(DW * MAX_BYTES + DW + 9);
   localparam int IDX_W = (DW > 1) ? $clog2(DW) : 1;
   localparam int END_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   rd_state_t        state;
   logic [CNT_W-1:0] bit_cnt;
   logic [IDX_W-1:0] bit_idx;
   logic [END_W-1:0] end_cnt;
   logic [2:0]       nbytes_reg;
   logic [DW-1:0]    cmd_sr;
   logic [DW-1:0]    rx_sr;

   logic sck_en;
   logic sck_rise;
   logic sck_fall;
   logic cmd_last;
   logic dummy_last;
   logic read_last;
   logic byte_last;

   assign sck_en     = (state == CMD) || (state == DUMMY) || (state == READ);
   assign cmd_last   = (int'(bit_cnt) == DW - 1);
   assign dummy_last = (int'(bit_cnt) == DUMMY_BITS - 1);
   assign read_last  = (int'(bit_cnt) == int'(nbytes_reg) * DW - 1);
   assign byte_last  = (int'(bit_idx) == DW - 1);

   ili9341_spi_reader_sck_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_sck_gen (
      .clk (clk),
      .rst (rst),
      .en  (sck_en),
      .sck (o_sck),
      .rise(sck_rise),
      .fall(sck_fall)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         bit_idx    <= '0;
         end_cnt    <= '0;
         nbytes_reg <= '0;
         cmd_sr     <= '0;
         rx_sr      <= '0;
         o_cs       <= 1'b1;
         o_mosi     <= 1'b1;
         o_dc       <= 1'b1;
         o_busy     <= 1'b0;
         o_rd_data  <= '0;
         o_rd_valid <= 1'b0;
         o_done     <= 1'b0;
      end else begin
         o_rd_valid <= 1'b0;
         o_done     <= 1'b0;
         case (state)
            IDLE: begin
               if (i_start) begin
                  state      <= CMD;
                  nbytes_reg <= 3'(clamp_nbytes(int'(i_nbytes), MAX_BYTES));
                  // First command bit goes out before the first SCK rise.
                  o_mosi     <= i_cmd[DW-1];
                  cmd_sr     <= i_cmd << 1;
                  o_cs       <= 1'b0;
                  o_dc       <= 1'b0;
                  o_busy     <= 1'b1;
                  bit_cnt    <= '0;
                  bit_idx    <= '0;
               end
            end
            CMD: begin
               if (sck_fall) begin
                  if (cmd_last) begin
                     bit_cnt <= '0;
                     o_mosi  <= 1'b1;
                     if (nbytes_reg == '0) begin
                        state   <= END;
                        end_cnt <= '0;
                     end else begin
                        o_dc  <= 1'b1;
                        state <= (DUMMY_BITS > 0) ? DUMMY : READ;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     o_mosi  <= cmd_sr[DW-1];
                     cmd_sr  <= cmd_sr << 1;
                  end
               end
            end
            DUMMY: begin
               if (sck_fall) begin
                  if (dummy_last) begin
                     bit_cnt <= '0;
                     state   <= READ;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            READ: begin
               if (sck_rise) begin
                  rx_sr <= {rx_sr[DW-2:0], i_miso};
                  if (byte_last) begin
                     bit_idx    <= '0;
                     o_rd_data  <= {rx_sr[DW-2:0], i_miso};
                     o_rd_valid <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
               // Leave on the final fall so every response bit gets a full SCK period.
               if (sck_fall) begin
                  if (read_last) begin
                     state   <= END;
                     end_cnt <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            END: begin
               if (int'(end_cnt) == CLK_DIV - 1) begin
                  state  <= IDLE;
                  o_cs   <= 1'b1;
                  o_dc   <= 1'b1;
                  o_busy <= 1'b0;
                  o_done <= 1'b1;
               end else begin
                  end_cnt <= end_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ili9341_spi_reader.sv
// Bench for ili9341_spi_reader: directed and random reads on a CLK_DIV=4 and a CLK_DIV=1
// instance against a behavioural MISO slave and a transaction-level expectation model.
`timescale 1ns/1ps
module tb_ili9341_spi_reader;
   import ili9341_spi_reader_pkg::*;

   localparam int D = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sel = 1'b0;
   logic       start = 1'b0;
   logic [7:0] cmd = 8'h00;
   logic [2:0] nbytes = 3'd0;
   logic       miso = 1'b0;

   always #5 clk = ~clk;

   logic start0, start1;
   logic sck0, mosi0, cs0, dc0, busy0, vld0, done0;
   logic sck1, mosi1, cs1, dc1, busy1, vld1, done1;
   logic [7:0] rdd0, rdd1;
   logic sck_m, mosi_m, cs_m, dc_m, busy_m, vld_m, done_m;
   logic [7:0] rdd_m;

   assign start0 = start & ~sel;
   assign start1 = start & sel;
   assign sck_m  = sel ? sck1  : sck0;
   assign mosi_m = sel ? mosi1 : mosi0;
   assign cs_m   = sel ? cs1   : cs0;
   assign dc_m   = sel ? dc1   : dc0;
   assign busy_m = sel ? busy1 : busy0;
   assign vld_m  = sel ? vld1  : vld0;
   assign done_m = sel ? done1 : done0;
   assign rdd_m  = sel ? rdd1  : rdd0;

   ili9341_spi_reader dut0 (
      .clk(clk), .rst(rst), .i_start(start0), .i_cmd(cmd), .i_nbytes(nbytes), .i_miso(miso),
      .o_sck(sck0), .o_mosi(mosi0), .o_cs(cs0), .o_dc(dc0), .o_busy(busy0),
      .o_rd_data(rdd0), .o_rd_valid(vld0), .o_done(done0)
   );

   ili9341_spi_reader #(.CLK_DIV(1)) dut1 (
      .clk(clk), .rst(rst), .i_start(start1), .i_cmd(cmd), .i_nbytes(nbytes), .i_miso(miso),
      .o_sck(sck1), .o_mosi(mosi1), .o_cs(cs1), .o_dc(dc1), .o_busy(busy1),
      .o_rd_data(rdd1), .o_rd_valid(vld1), .o_done(done1)
   );

   int n_chk = 0;
   int n_fail = 0;

   // Slave response bytes for the current transaction, written by the stimulus only.
   logic [7:0] slv_b [4];
   int         slv_n = 0;

   // Transaction observations, rebuilt on every CS fall.
   int         m_rises = 0, m_cs_low = 0, m_dc_err = 0, m_done = 0, slv_idx = 0;
   logic [7:0] m_cmd = 8'h00;
   logic [7:0] m_rx [$];
   logic       sck_prev = 1'b0, cs_prev = 1'b1, mosi_prev = 1'b1;
   logic [7:0] cur;

   initial begin
      forever begin
         @(negedge clk);
         if (!cs_m && cs_prev) begin
            m_rises = 0; m_cs_low = 0; m_cmd = 8'h00; m_dc_err = 0; m_done = 0;
            slv_idx = 0; m_rx.delete();
         end
         if (!cs_m) m_cs_low++;
         if (sck_m && sck_prev && mosi_m !== mosi_prev) m_dc_err++;
         if (sck_m && !sck_prev) begin
            if (m_rises < 8) begin
               m_cmd = {m_cmd[6:0], mosi_m};
               if (dc_m !== 1'b0) m_dc_err++;
            end else if (dc_m !== 1'b1 || mosi_m !== 1'b1) begin
               m_dc_err++;
            end
            m_rises++;
         end
         if (!sck_m && sck_prev && !cs_m && m_rises >= 8 + D && slv_idx < slv_n * 8) begin
            cur = slv_b[slv_idx / 8];
            miso = cur[7 - (slv_idx % 8)];
            slv_idx++;
         end
         if (vld_m) m_rx.push_back(rdd_m);
         if (done_m) m_done++;
         sck_prev = sck_m; cs_prev = cs_m; mosi_prev = mosi_m;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_rises(input int r, input string tag);
      for (int k = 0; k < 3000 && m_rises < r; k++) begin
         @(posedge clk); #1;
      end
      chk({tag, "_reach_rise"}, 32'(m_rises >= r), 1);
   endtask

   // Waits for the done pulse and compares the whole transaction with the expected shape.
   task automatic finish_check(input logic [7:0] c, input logic [2:0] n, input string tag,
                               input bit chained);
      int ne, er, el, cd;
      ne = (n > 3'd4) ? 4 : int'(n);
      cd = sel ? 1 : 4;
      er = 8 + ((ne > 0) ? D + 8 * ne : 0);
      el = er * 2 * cd + cd;
      @(negedge clk);
      for (int k = 0; k < 3000 && m_done == 0; k++) begin
         @(posedge clk); #1;
      end
      chk({tag, "_done"}, 32'(m_done), 1);
      chk({tag, "_cs_low_clk"}, 32'(m_cs_low), 32'(el));
      chk({tag, "_sck_rises"}, 32'(m_rises), 32'(er));
      chk({tag, "_mosi_cmd"}, m_cmd, c);
      chk({tag, "_dc_mosi_err"}, 32'(m_dc_err), 0);
      chk({tag, "_nvalid"}, 32'(m_rx.size()), 32'(ne));
      for (int i = 0; i < ne; i++)
         chk($sformatf("%s_byte%0d", tag, i), (i < m_rx.size()) ? 32'(m_rx[i]) : 32'hDEAD, slv_b[i]);
      chk({tag, "_done_pulse_width"}, done_m, 0);
      chk({tag, "_busy_after"}, busy_m, chained ? 1 : 0);
      if (!chained) begin
         repeat (4) @(posedge clk);
         #1;
         chk({tag, "_single_done"}, 32'(m_done), 1);
      end
   endtask

   task automatic do_txn(input logic [7:0] c, input logic [2:0] n, input string tag);
      slv_n = (n > 3'd4) ? 4 : int'(n);
      @(negedge clk);
      cmd = c; nbytes = n; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_busy_on_accept"}, busy_m, 1);
      chk({tag, "_cs_on_accept"}, cs_m, 0);
      chk({tag, "_dc_on_accept"}, dc_m, 0);
      chk({tag, "_mosi_first"}, mosi_m, c[7]);
      finish_check(c, n, tag, 1'b0);
   endtask

   task automatic rand_bytes();
      for (int i = 0; i < 4; i++) slv_b[i] = 8'($urandom);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 4; i++) slv_b[i] = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_cs", cs_m, 1);
      chk("rst_sck", sck_m, 0);
      chk("rst_mosi", mosi_m, 1);
      chk("rst_dc", dc_m, 1);
      chk("rst_busy", busy_m, 0);
      chk("rst_rd_data", rdd_m, 0);
      chk("rst_rd_valid", vld_m, 0);
      chk("rst_done", done_m, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // RDID4 with a known three-byte answer
      slv_b[0] = 8'h00; slv_b[1] = 8'h93; slv_b[2] = 8'h41; slv_b[3] = 8'h00;
      do_txn(CMD_RDID4, 3'd3, "rdid4");

      // command only
      do_txn(8'h29, 3'd0, "cmd_only");

      // oversize request clamps to four bytes
      slv_b[0] = 8'hA5; slv_b[1] = 8'h5A; slv_b[2] = 8'hFF; slv_b[3] = 8'h00;
      do_txn(8'hDA, 3'd7, "clamp");

      // starts while busy are dropped; start on the done cycle is taken
      slv_b[0] = 8'hC3; slv_b[1] = 8'h18;
      slv_n = 2;
      @(negedge clk);
      cmd = CMD_RDID4; nbytes = 3'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_rises(13, "busy_mid");
      @(negedge clk);
      cmd = 8'h55; nbytes = 3'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_rises(25, "busy_end");
      cmd = CMD_RDDID; nbytes = 3'd0; slv_n = 0; start = 1'b1;
      finish_check(CMD_RDID4, 3'd2, "busy_first", 1'b1);
      start = 1'b0;
      finish_check(CMD_RDDID, 3'd0, "busy_second", 1'b0);

      // reset in the middle of a read
      rand_bytes();
      slv_n = 4;
      @(negedge clk);
      cmd = CMD_RDDST; nbytes = 3'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_rises(20, "abort");
      #2 rst = 1'b0;
      #1;
      chk("abort_cs", cs_m, 1);
      chk("abort_sck", sck_m, 0);
      chk("abort_busy", busy_m, 0);
      chk("abort_valid", vld_m, 0);
      chk("abort_rd_data", rdd_m, 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("abort_no_done", 32'(m_done), 0);
      chk("abort_bytes_before", 32'(m_rx.size()), 1);
      rand_bytes();
      do_txn(8'($urandom), 3'd2, "after_abort");

      for (int t = 0; t < 6; t++) begin
         rand_bytes();
         do_txn(8'($urandom), 3'($urandom_range(0, 7)), $sformatf("rand_div4_%0d", t));
      end

      // fastest divider: SCK = clk/2
      sel = 1'b1;
      repeat (2) @(negedge clk);
      slv_b[0] = 8'h80; slv_b[1] = 8'h01; slv_b[2] = 8'hC3; slv_b[3] = 8'h3C;
      do_txn(CMD_RDDST, 3'd4, "div1_rddst");
      for (int t = 0; t < 4; t++) begin
         rand_bytes();
         do_txn(8'($urandom), 3'($urandom_range(0, 7)), $sformatf("rand_div1_%0d", t));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
